// File: rtl/accum_seq_pkg.sv
// Shared definitions for the AdderAccumulator sequencer: output_sel mux codes,
// settle bound, the main FSM state encoding and the readback phase encoding.
package accum_seq_pkg;

    localparam int MUX_SEL_W = 3;

    localparam logic [MUX_SEL_W-1:0] MUX_SEL_REGISTER_1     = 3'd0;
    localparam logic [MUX_SEL_W-1:0] MUX_SEL_REGISTER_2_LSB = 3'd1;
    localparam logic [MUX_SEL_W-1:0] MUX_SEL_REGISTER_2_MSB = 3'd2;
    localparam logic [MUX_SEL_W-1:0] MUX_SEL_COUNTER_CARRY  = 3'd3;

    localparam int SETTLE_MAX = 3;

    // The three read steps share one FSM state; the readback block sequences them.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_FETCH = 3'd2,
        ST_LOAD  = 3'd3,
        ST_ADD   = 3'd4,
        ST_READ  = 3'd5,
        ST_DONE  = 3'd6
    } seq_state_e;

    typedef enum logic [1:0] {
        PH_LSB   = 2'd0,
        PH_MSB   = 2'd1,
        PH_CARRY = 2'd2
    } rd_phase_e;

    function automatic logic [MUX_SEL_W-1:0] phase_sel(input rd_phase_e ph);
        logic [MUX_SEL_W-1:0] sel;
        sel = MUX_SEL_REGISTER_2_LSB;
        case (ph)
            PH_MSB:   sel = MUX_SEL_REGISTER_2_MSB;
            PH_CARRY: sel = MUX_SEL_COUNTER_CARRY;
            default:  sel = MUX_SEL_REGISTER_2_LSB;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/accum_readback.sv
// Readback sequencer: steps output_sel through sum LSB, sum MSB and carry count,
// holding each for SETTLE+1 cycles and capturing data_out on the last one.
module accum_readback
    import accum_seq_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int SEL_W  = MUX_SEL_W,
    parameter int SETTLE = 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                clear,
    input  logic                reading,
    input  logic [DATA_W-1:0]   acc_data_out,
    output logic                read_done,
    output logic [SEL_W-1:0]    acc_output_sel,
    output logic [2*DATA_W-1:0] result,
    output logic [DATA_W-1:0]   result_carry
);

    localparam int         SETTLE_EFF  = (SETTLE > SETTLE_MAX) ? SETTLE_MAX : SETTLE;
    localparam logic [1:0] SETTLE_LAST = 2'(SETTLE_EFF);

    rd_phase_e             phase_q, phase_d;
    logic [1:0]            cnt_q, cnt_d;
    logic [SEL_W-1:0]      sel_q, sel_d;
    logic [2*DATA_W-1:0]   result_q, result_d;
    logic [DATA_W-1:0]     carry_q, carry_d;
    logic                  last;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        phase_d   = phase_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        carry_d   = carry_q;
        last      = reading && (cnt_q == SETTLE_LAST);
        read_done = last && (phase_q == PH_CARRY);

        if (clear) begin
            result_d = '0;
            carry_d  = '0;
        end

        if (!reading) begin
            cnt_d   = '0;
            phase_d = PH_LSB;
        end else if (last) begin
            cnt_d = '0;
            unique case (phase_q)
                PH_LSB: begin
                    result_d[DATA_W-1:0] = acc_data_out;
                    phase_d              = PH_MSB;
                end
                PH_MSB: begin
                    result_d[2*DATA_W-1:DATA_W] = acc_data_out;
                    phase_d                     = PH_CARRY;
                end
                PH_CARRY: begin
                    carry_d = acc_data_out;
                    phase_d = PH_LSB;
                end
                default: phase_d = PH_LSB;
            endcase
        end else begin
            cnt_d = cnt_q + 2'd1;
        end

        // Select is registered from the next phase so it is already valid on phase entry.
        sel_d = SEL_W'(phase_sel(phase_d));
    end

    // NOTE: state is updated with non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            phase_q  <= PH_LSB;
            cnt_q    <= '0;
            sel_q    <= SEL_W'(MUX_SEL_REGISTER_2_LSB);
            result_q <= '0;
            carry_q  <= '0;
        end else begin
            phase_q  <= phase_d;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            result_q <= result_d;
            carry_q  <= carry_d;
        end
    end

    assign acc_output_sel = sel_q;
    assign result         = result_q;
    assign result_carry   = carry_q;

endmodule

// File: rtl/accum_sequencer.sv
// Upstream controller for AdderAccumulator: accepts an operand burst, clears the
// accumulator, issues load/add pairs per operand, then reads back sum and carry.
module accum_sequencer
    import accum_seq_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 8,
    parameter int SEL_W  = MUX_SEL_W,
    parameter int SETTLE = 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [LEN_W-1:0]    burst_len,
    input  logic                in_valid,
    input  logic [DATA_W-1:0]   in_data,
    output logic                in_ready,
    output logic                acc_reset,
    output logic                acc_load,
    output logic                acc_add,
    output logic [DATA_W-1:0]   acc_data,
    output logic [SEL_W-1:0]    acc_output_sel,
    input  logic [DATA_W-1:0]   acc_data_out,
    output logic                busy,
    output logic                done,
    output logic [2*DATA_W-1:0] result,
    output logic [DATA_W-1:0]   result_carry
);

    seq_state_e        state_q, state_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [DATA_W-1:0] acc_data_q, acc_data_d;
    logic              in_ready_q, in_ready_d;
    logic              acc_reset_q, acc_reset_d;
    logic              acc_load_q, acc_load_d;
    logic              acc_add_q, acc_add_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              read_done;

    accum_readback #(
        .DATA_W (DATA_W),
        .SEL_W  (SEL_W),
        .SETTLE (SETTLE)
    ) u_readback (
        .clock          (clock),
        .reset          (reset),
        .clear          (state_q == ST_CLEAR),
        .reading        (state_q == ST_READ),
        .acc_data_out   (acc_data_out),
        .read_done      (read_done),
        .acc_output_sel (acc_output_sel),
        .result         (result),
        .result_carry   (result_carry)
    );

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        acc_data_d = acc_data_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    rem_d   = burst_len;
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: state_d = (rem_q == '0) ? ST_READ : ST_FETCH;
            ST_FETCH: begin
                if (in_valid && in_ready_q) begin
                    acc_data_d = in_data;
                    state_d    = ST_LOAD;
                end
            end
            ST_LOAD: state_d = ST_ADD;
            ST_ADD: begin
                if (rem_q != '0) begin
                    rem_d = rem_q - LEN_W'(1);
                end
                state_d = (rem_q <= LEN_W'(1)) ? ST_READ : ST_FETCH;
            end
            ST_READ: begin
                if (read_done) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Outputs decode the next state so each registered output lines up with its state.
        in_ready_d  = (state_d == ST_FETCH);
        acc_reset_d = (state_d == ST_IDLE) || (state_d == ST_CLEAR);
        acc_load_d  = (state_d == ST_LOAD);
        acc_add_d   = (state_d == ST_ADD);
        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_d == ST_DONE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            rem_q       <= '0;
            acc_data_q  <= '0;
            in_ready_q  <= 1'b0;
            acc_reset_q <= 1'b1;
            acc_load_q  <= 1'b0;
            acc_add_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            acc_data_q  <= acc_data_d;
            in_ready_q  <= in_ready_d;
            acc_reset_q <= acc_reset_d;
            acc_load_q  <= acc_load_d;
            acc_add_q   <= acc_add_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign acc_reset = acc_reset_q;
    assign acc_load  = acc_load_q;
    assign acc_add   = acc_add_q;
    assign acc_data  = acc_data_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
